// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte requesters,
// with bounded bursts and a watchdog on the transmitter's active response.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 64,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [IW-1:0]        o_Grant_Id,
    output logic                 o_Busy,
    output logic                 o_Timeout
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_ACT, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick, idx, sel;
    logic [BW-1:0] burst_q, burst_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d, timeout_q, timeout_d;
    logic          any_valid, done_evt, cont, take_new, take_cont, expired, release_burst;

    // Walk downwards so the nearest requester after the pointer wins.
    always_comb begin
        idx  = '0;
        pick = ptr_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (i_Req_Valid[idx]) pick = idx;
        end
    end

    assign any_valid     = |i_Req_Valid;
    assign done_evt      = i_Tx_Done && (state_q == WAIT_ACT || state_q == WAIT_DONE);
    assign cont          = !last_q && burst_q < BW'(MAX_BURST) && i_Req_Valid[grant_q];
    assign take_new      = state_q == IDLE && any_valid;
    assign take_cont     = done_evt && cont;
    assign expired       = state_q == WAIT_ACT && !i_Tx_Done && !i_Tx_Active && wdog_q == WW'(TIMEOUT - 1);
    assign release_burst = (done_evt && !cont) || expired;
    assign sel           = take_new ? pick : grant_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NUM_REQ - 1);
            grant_q   <= '0;
            burst_q   <= '0;
            wdog_q    <= '0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            burst_q   <= burst_d;
            wdog_q    <= wdog_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = any_valid ? START : IDLE;
            START:    state_d = WAIT_ACT;
            WAIT_ACT: state_d = done_evt ? (cont ? START : IDLE) :
                                i_Tx_Active ? WAIT_DONE : expired ? IDLE : WAIT_ACT;
            default:  state_d = done_evt ? (cont ? START : IDLE) : WAIT_DONE;
        endcase
        ptr_d     = release_burst ? grant_q : ptr_q;
        grant_d   = take_new ? pick : grant_q;
        burst_d   = take_new ? BW'(1) : take_cont ? burst_q + 1'b1 : burst_q;
        wdog_d    = state_q == START ? '0 : (state_q == WAIT_ACT && !i_Tx_Active) ? wdog_q + 1'b1 : wdog_q;
        byte_d    = (take_new || take_cont) ? i_Req_Byte[{sel, 3'b000} +: 8] : byte_q;
        last_d    = (take_new || take_cont) ? i_Req_Last[sel] : last_q;
        timeout_d = timeout_q | expired;
    end

    always_comb begin
        o_Req_Ready = '0;
        if (take_new) o_Req_Ready[pick] = 1'b1;
        if (take_cont) o_Req_Ready[grant_q] = 1'b1;
        o_Tx_DV = state_q == START;
        o_Busy  = state_q != IDLE;
    end

    assign o_Tx_Byte  = byte_q;
    assign o_Grant_Id = grant_q;
    assign o_Timeout  = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: requester queues and a UART TX model drive the arbiter; a byte
// scoreboard checks every DV, and event logs check grant order and cycle timing.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int FRAME = 4;
    localparam int HMAX  = 20000;

    logic           clk = 1'b0;
    logic           i_Reset;
    logic [N-1:0]   i_Req_Valid, i_Req_Last, o_Req_Ready;
    logic [8*N-1:0] i_Req_Byte;
    logic           o_Tx_DV, i_Tx_Active, i_Tx_Done, o_Busy, o_Timeout;
    logic [7:0]     o_Tx_Byte;
    logic [1:0]     o_Grant_Id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4), .TIMEOUT(64)) dut (
        .i_Clock(clk), .i_Reset(i_Reset),
        .i_Req_Valid(i_Req_Valid), .i_Req_Byte(i_Req_Byte), .i_Req_Last(i_Req_Last),
        .o_Req_Ready(o_Req_Ready), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
        .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .o_Grant_Id(o_Grant_Id),
        .o_Busy(o_Busy), .o_Timeout(o_Timeout)
    );

    typedef struct { logic [3:0] vmask; logic [7:0] order; } vec_t;

    int         checks = 0, errors = 0, cyc = 0;
    logic [8:0] rq_mem [N][64];
    int         rq_head [N], rq_tail [N];
    logic [N-1:0] en, hs_pend;
    logic [9:0] sb [$];
    int         hs_id [$], hs_cyc [$], dv_cyc [$], done_cyc [$];
    logic       busy_hist [HMAX], to_hist [HMAX];
    logic       tx_en, tx_busy, force_done, model_done;
    int         tx_cnt;
    logic [7:0] cur_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int k = 0; k < N; k++) if (en[k] && rq_head[k] != rq_tail[k]) p = 1'b1;
        return p;
    endfunction

    task automatic push(input int k, input logic [7:0] b, input logic last);
        rq_mem[k][rq_tail[k]] = {last, b};
        rq_tail[k]++;
    endtask

    task automatic clear_logs();
        hs_id.delete(); hs_cyc.delete(); dv_cyc.delete(); done_cyc.delete();
    endtask

    // One clock: drive inputs just after the edge, observe at the falling edge.
    task automatic step();
        logic [8:0] f;
        logic [9:0] e;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) if (hs_pend[k]) rq_head[k]++;
        hs_pend    = '0;
        model_done = 1'b0;
        if (force_done) begin
            i_Tx_Active = 1'b0;
            i_Tx_Done   = 1'b1;
        end else if (tx_busy) begin
            tx_cnt++;
            i_Tx_Active = tx_cnt < FRAME;
            i_Tx_Done   = tx_cnt == FRAME;
            model_done  = i_Tx_Done;
            if (i_Tx_Done) tx_busy = 1'b0;
        end else begin
            i_Tx_Active = 1'b0;
            i_Tx_Done   = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            f = rq_mem[k][rq_head[k]];
            i_Req_Valid[k]       = en[k] && rq_head[k] != rq_tail[k];
            i_Req_Byte[8*k +: 8] = f[7:0];
            i_Req_Last[k]        = f[8];
        end
        @(negedge clk);
        if (cyc < HMAX) begin
            busy_hist[cyc] = o_Busy;
            to_hist[cyc]   = o_Timeout;
        end
        if (o_Req_Ready != '0) begin
            chk("ready_onehot", 32'($countones(o_Req_Ready)), 1);
            chk("ready_without_valid", 32'(o_Req_Ready & ~i_Req_Valid), 0);
        end
        hs_pend = i_Req_Valid & o_Req_Ready;
        for (int k = 0; k < N; k++) if (hs_pend[k]) begin
            f = rq_mem[k][rq_head[k]];
            hs_id.push_back(k);
            hs_cyc.push_back(cyc);
            sb.push_back({2'(k), f[7:0]});
        end
        if (model_done) chk("byte_held", 32'(o_Tx_Byte), 32'(cur_byte));
        if (i_Tx_Done) done_cyc.push_back(cyc);
        if (o_Tx_DV) begin
            dv_cyc.push_back(cyc);
            chk("dv_while_outstanding", 32'(tx_busy), 0);
            chk("dv_has_accepted_byte", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("tx_byte", 32'(o_Tx_Byte), 32'(e[7:0]));
                chk("grant_id", 32'(o_Grant_Id), 32'(e[9:8]));
                cur_byte = e[7:0];
            end
            if (tx_en) begin
                tx_busy = 1'b1;
                tx_cnt  = 0;
            end
        end
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while ((pending() || o_Busy || tx_busy) && n < max);
        chk({name, "_drain_bound"}, 32'(n < max), 1);
    endtask

    task automatic do_reset();
        i_Reset    = 1'b1;
        tx_busy    = 1'b0;
        force_done = 1'b0;
        hs_pend    = '0;
        for (int k = 0; k < N; k++) begin
            rq_head[k] = 0;
            rq_tail[k] = 0;
        end
        sb.delete();
        step();
        step();
        i_Reset = 1'b0;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_ready"}, 32'(o_Req_Ready), 0);
        chk({p, "_dv"}, 32'(o_Tx_DV), 0);
        chk({p, "_byte"}, 32'(o_Tx_Byte), 0);
        chk({p, "_grant"}, 32'(o_Grant_Id), 0);
        chk({p, "_busy"}, 32'(o_Busy), 0);
        chk({p, "_timeout"}, 32'(o_Timeout), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL sim_watchdog: got no finish expected finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        int   h, n;
        vecs[0] = '{4'b0001, 8'h00};
        vecs[1] = '{4'b1001, 8'h03};
        vecs[2] = '{4'b0110, 8'h09};
        vecs[3] = '{4'b1111, 8'h93};
        vecs[4] = '{4'b0100, 8'h02};
        vecs[5] = '{4'b0101, 8'h08};
        vecs[6] = '{4'b1010, 8'h07};
        vecs[7] = '{4'b1100, 8'h0E};
        i_Reset = 1'b1; i_Req_Valid = '0; i_Req_Last = '0; i_Req_Byte = '0;
        i_Tx_Active = 1'b0; i_Tx_Done = 1'b0;
        en = '1; tx_en = 1'b1; tx_busy = 1'b0; force_done = 1'b0; model_done = 1'b0;
        hs_pend = '0; tx_cnt = 0; cur_byte = '0;
        for (int k = 0; k < N; k++) for (int j = 0; j < 64; j++) rq_mem[k][j] = '0;
        do_reset();
        check_reset("rst");

        clear_logs();
        push(0, 8'hA5, 1'b1);
        drain("t1", 100);
        chk("t1_hs_count", 32'(hs_id.size()), 1);
        if (hs_id.size() == 1 && dv_cyc.size() == 1 && done_cyc.size() == 1) begin
            chk("t1_grant", 32'(hs_id[0]), 0);
            chk("t1_dv_latency", 32'(dv_cyc[0] - hs_cyc[0]), 1);
            chk("t1_busy_at_done", 32'(busy_hist[done_cyc[0]]), 1);
            chk("t1_idle_after_done", 32'(busy_hist[done_cyc[0] + 1]), 0);
        end

        for (int r = 0; r < 8; r++) begin
            clear_logs();
            for (int k = 0; k < N; k++) if (vecs[r].vmask[k]) push(k, 8'(8'h40 + 16 * r + k), 1'b1);
            drain($sformatf("vec%0d", r), 200);
            chk($sformatf("vec%0d_count", r), 32'(hs_id.size()), 32'($countones(vecs[r].vmask)));
            for (int i = 0; i < $countones(vecs[r].vmask) && i < hs_id.size(); i++)
                chk($sformatf("vec%0d_grant%0d", r, i), 32'(hs_id[i]), 32'(vecs[r].order[2*i +: 2]));
        end

        do_reset();
        clear_logs();
        for (int k = 0; k < N; k++) for (int j = 0; j < 8; j++) push(k, 8'(16 * k + j), 1'b0);
        drain("t2", 1000);
        chk("t2_hs_count", 32'(hs_id.size()), 32);
        chk("t2_done_count", 32'(done_cyc.size()), 32);
        if (hs_id.size() == 32 && dv_cyc.size() == 32 && done_cyc.size() == 32) begin
            for (int i = 0; i < 32; i++) chk($sformatf("t2_grant%0d", i), 32'(hs_id[i]), 32'((i / 4) % 4));
            for (int i = 0; i < 31; i++)
                chk($sformatf("t2_gap%0d", i), 32'(dv_cyc[i+1] - done_cyc[i]), (i % 4 == 3) ? 2 : 1);
        end

        do_reset();
        clear_logs();
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        push(3, 8'h30, 1'b1);
        drain("t3", 200);
        chk("t3_hs_count", 32'(hs_id.size()), 4);
        if (hs_id.size() == 4 && dv_cyc.size() == 4 && done_cyc.size() == 4) begin
            chk("t3_id0", 32'(hs_id[0]), 2);
            chk("t3_id1", 32'(hs_id[1]), 2);
            chk("t3_id2", 32'(hs_id[2]), 2);
            chk("t3_id3", 32'(hs_id[3]), 3);
            chk("t3_burst_gap", 32'(dv_cyc[1] - done_cyc[0]), 1);
            chk("t3_rearb_gap", 32'(dv_cyc[3] - done_cyc[2]), 2);
        end

        do_reset();
        clear_logs();
        tx_en = 1'b0;
        push(1, 8'h11, 1'b1);
        push(2, 8'h22, 1'b1);
        drain("t4", 400);
        chk("t4_hs_count", 32'(hs_id.size()), 2);
        if (hs_id.size() == 2 && dv_cyc.size() >= 1) begin
            h = hs_cyc[0];
            chk("t4_first_id", 32'(hs_id[0]), 1);
            chk("t4_dv_latency", 32'(dv_cyc[0] - h), 1);
            chk("t4_timeout_before", 32'(to_hist[h + 65]), 0);
            chk("t4_timeout_set", 32'(to_hist[h + 66]), 1);
            chk("t4_idle_after_timeout", 32'(busy_hist[h + 66]), 0);
            chk("t4_next_id", 32'(hs_id[1]), 2);
            chk("t4_next_accept", 32'(hs_cyc[1] - h), 66);
        end
        tx_en = 1'b1;
        push(0, 8'h33, 1'b1);
        drain("t4b", 100);
        chk("t4_timeout_sticky", 32'(o_Timeout), 1);
        do_reset();
        chk("t4_timeout_cleared", 32'(o_Timeout), 0);

        clear_logs();
        push(0, 8'h5A, 1'b1);
        n = 0;
        while (dv_cyc.size() == 0 && n < 50) begin
            step();
            n++;
        end
        chk("t5_dv_seen", 32'(dv_cyc.size()), 1);
        step();
        step();
        chk("t5_busy_in_wait_done", 32'(o_Busy), 1);
        chk("t5_byte_before_reset", 32'(o_Tx_Byte), 32'h5A);
        i_Reset = 1'b1;
        tx_busy = 1'b0;
        sb.delete();
        step();
        i_Reset = 1'b0;
        clear_logs();
        step();
        check_reset("t5");
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        repeat (4) step();
        chk("t5_no_dv", 32'(dv_cyc.size()), 0);
        chk("t5_no_ready", 32'(hs_id.size()), 0);
        chk("t5_still_idle", 32'(o_Busy), 0);
        push(1, 8'h77, 1'b1);
        drain("t5", 100);
        chk("t5_recovers", 32'(hs_id.size()), 1);

        do_reset();
        clear_logs();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
        push(1, 8'h10, 1'b1);
        n = 0;
        while (hs_id.size() == 0 && n < 50) begin
            step();
            n++;
        end
        en[0] = 1'b0;
        drain("t6", 200);
        chk("t6_hs_count", 32'(hs_id.size()), 2);
        if (hs_id.size() == 2) begin
            chk("t6_id0", 32'(hs_id[0]), 0);
            chk("t6_id1", 32'(hs_id[1]), 1);
        end
        en[0] = 1'b1;
        drain("t6b", 200);
        chk("t6_total", 32'(hs_id.size()), 4);
        if (hs_id.size() == 4) begin
            chk("t6_id2", 32'(hs_id[2]), 0);
            chk("t6_id3", 32'(hs_id[3]), 0);
        end
        chk("sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration with bounded bursts. Each requester presents bytes on a valid/ready handshake. The arbiter latches the granted byte and pulses the transmitter's data-valid strobe. It then waits for the transmitter's done pulse before sending the next byte. It sits between the TX-side clients (command responder, debug logger, and so on) and the tx modport of the UART interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, maximum bytes sent back-to-back for one requester before re-arbitration (1..16)
TIMEOUT, 64, cycles to wait for i_Tx_Active after o_Tx_DV before declaring the transmitter stuck

Ports:
i_Clock  input  1  system clock; all logic on rising edge
i_Reset  input  1  synchronous, active-high reset
i_Req_Valid  input  NUM_REQ  per-requester byte valid
i_Req_Byte  input  8*NUM_REQ  per-requester byte; requester k occupies bits [8k+7:8k]
i_Req_Last  input  NUM_REQ  byte being offered ends that requester's burst
o_Req_Ready  output  NUM_REQ  one-hot accept; a byte is taken when valid and ready are both high
o_Tx_DV  output  1  one-cycle strobe to UART TX i_Tx_DV
o_Tx_Byte  output  8  byte to UART TX i_Tx_Byte; held stable from the DV cycle until done
i_Tx_Active  input  1  from UART TX o_Tx_Active
i_Tx_Done  input  1  from UART TX o_Tx_Done, one-cycle pulse
o_Grant_Id  output  $clog2(NUM_REQ)  requester currently owning the transmitter
o_Busy  output  1  high in any state other than IDLE
o_Timeout  output  1  sticky error flag; cleared only by i_Reset

Behaviour:
- Reset values: state=IDLE, o_Req_Ready=0, o_Tx_DV=0, o_Tx_Byte=0, o_Grant_Id=0, o_Busy=0, o_Timeout=0, rr pointer=NUM_REQ-1, burst count=0, watchdog=0.
- Arbitration: search starts at (pointer+1) mod NUM_REQ and picks the first asserted i_Req_Valid, wrapping past NUM_REQ-1 to 0. The pointer is loaded with the grant id only when a burst is released.
- o_Req_Ready is combinational (Mealy). It is one-hot or zero, and asserts only in the accept windows below. The accepted byte and its i_Req_Last bit are registered on that edge.
- States:
  - IDLE: if any i_Req_Valid, assert o_Req_Ready[g], set o_Grant_Id=g, set burst count=1, go to START. Otherwise stay in IDLE.
  - START (1 cycle): o_Tx_DV=1 with o_Tx_Byte equal to the latched byte; watchdog cleared; go to WAIT_ACT.
  - WAIT_ACT: when i_Tx_Active=1, go to WAIT_DONE. Each cycle without it increments the watchdog. When the watchdog reaches TIMEOUT, set o_Timeout=1, release the burst, and go to IDLE.
  - WAIT_DONE: when i_Tx_Done=1, decide whether to continue:
    - Continue if all three hold: the latched last bit is 0, burst count < MAX_BURST, and i_Req_Valid[grant] is high. Then assert o_Req_Ready[grant] in this same cycle, increment burst count, and go to START.
    - Otherwise release the burst (pointer=grant) and go to IDLE.
  - If i_Tx_Done arrives in WAIT_ACT together with or without i_Tx_Active, treat it as WAIT_DONE completion.
- Throughput: accept edge, then DV one cycle later. The done-to-next-DV gap is 1 cycle within a burst and 2 cycles across a re-arbitration (done, IDLE accept, START).
- o_Tx_DV is never asserted while the transmitter is between DV and done. At most one byte is outstanding.
- A requester dropping valid mid-burst ends the burst at the next done. No byte is lost; bytes are taken only on handshake.
- i_Reset mid-operation returns all state to reset values on the next edge. An in-flight UART frame is not aborted, and the arbiter does not track it. A done pulse arriving later while in IDLE is ignored.
- NUM_REQ=1 degenerates to a pass-through with burst limiting.

Test Plan:
- Single requester 0 offers 0xA5 with last=1 -> ready[0] pulses once; o_Tx_DV pulses 1 cycle later with o_Tx_Byte=0xA5; arbiter is back in IDLE one cycle after i_Tx_Done; o_Busy falls.
- Requesters 0..3 all valid continuously, last=0, MAX_BURST=4 -> grants run 0,1,2,3,0 with exactly 4 bytes each; ready pulses are one-hot; pointer wraps from 3 to 0.
- Requester 2 sends 3 bytes with last on byte 2 while requester 3 is valid -> bytes 0,1,2 go from req 2; the next grant is 3 after the 2-cycle re-arbitration gap.
- Requester 1 valid and i_Tx_Active held at 0 -> after 64 cycles in WAIT_ACT, o_Timeout=1, arbiter returns to IDLE and services the next request; o_Timeout stays 1 until reset.
- Assert i_Reset during WAIT_DONE, then a stray i_Tx_Done arrives after reset -> all outputs return to reset values; the stray done produces no DV and no ready.
- Requester 0 deasserts valid right after its first byte in a burst while requester 1 is valid -> the burst ends at the done, and requester 1 is granted next.
